// File: rtl/multi_edge_debouncer.sv
// multi_edge_debouncer
//   Multi-channel synchroniser + debouncer for board-level buttons/switches.
//   Each channel synchronises its raw input through SYNC_STAGES flops.
//   It then accepts a new level only after the input has been stable for Teff
//   cycles, where Teff = max(T,1).
//   Each channel provides a registered clean level and one-cycle rise/fall
//   pulses aligned with the level change. It also provides a sticky event flag
//   whose setting edge(s) are chosen per channel.
//
// Ports:
//   iCLK            system clock, rising edge
//   iRST            synchronous active-high reset
//   iTrigger_in     raw asynchronous inputs, one bit per channel
//   iDebounce_value stability threshold T (cycles), shared by all channels
//   iEdge_mode      per-channel event mode in [2i+1:2i]: 00 none, 01 rise,
//                   10 fall, 11 both
//   iEvent_clr      per-channel clear of the sticky event flag
//   oLevel          debounced level
//   oRising_edge    one-cycle pulse when oLevel goes 0->1
//   oFalling_edge   one-cycle pulse when oLevel goes 1->0
//   oEvent          sticky event flag
//   oBusy           high while the channel's stability counter is non-zero
module multi_edge_debouncer #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [CHANNELS-1:0]   iTrigger_in,
  input  logic [CNT_WIDTH-1:0]  iDebounce_value,
  input  logic [2*CHANNELS-1:0] iEdge_mode,
  input  logic [CHANNELS-1:0]   iEvent_clr,
  output logic [CHANNELS-1:0]   oLevel,
  output logic [CHANNELS-1:0]   oRising_edge,
  output logic [CHANNELS-1:0]   oFalling_edge,
  output logic [CHANNELS-1:0]   oEvent,
  output logic [CHANNELS-1:0]   oBusy
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Acceptance limit Teff-1; T=0 is treated exactly like T=1.
  logic [CNT_WIDTH-1:0] limit_s;

  // Derive the shared acceptance limit from the runtime threshold
  always_comb begin
    limit_s = CNT_ZERO;
    if (iDebounce_value != CNT_ZERO) begin
      limit_s = iDebounce_value - CNT_ONE;
    end else begin
      limit_s = CNT_ZERO;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic                   level_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   event_r;
    logic                   busy_r;
    logic                   sample_s;
    logic                   differ_s;
    logic                   accept_s;
    logic                   set_s;
    logic [1:0]             mode_s;

    // Only the last synchroniser stage is allowed to feed the filter
    always_comb begin
      sample_s = sync_r[SYNC_STAGES-1];
      differ_s = (sample_s != level_r);
      // >= (not ==) so a threshold lowered below a running count accepts at once
      accept_s = differ_s && (cnt_r >= limit_s);
      mode_s   = iEdge_mode[2*i +: 2];
    end

    // Select which registered pulse(s) may set the sticky flag
    always_comb begin
      set_s = 1'b0;
      case (mode_s)
        2'b01:   set_s = rise_r;
        2'b10:   set_s = fall_r;
        2'b11:   set_s = rise_r | fall_r;
        default: set_s = 1'b0;
      endcase
    end

    // Synchroniser shift chain for the raw asynchronous input
    always_ff @(posedge iCLK) begin
      if (iRST) begin
        sync_r <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], iTrigger_in[i]};
      end
    end

    // Stability counter, debounced level and aligned edge pulses
    always_ff @(posedge iCLK) begin
      if (iRST) begin
        cnt_r   <= CNT_ZERO;
        busy_r  <= 1'b0;
        level_r <= RESET_LEVEL;
        rise_r  <= 1'b0;
        fall_r  <= 1'b0;
      end else if (!differ_s) begin
        // Input agrees with the level: any partial count was a glitch
        cnt_r   <= CNT_ZERO;
        busy_r  <= 1'b0;
        rise_r  <= 1'b0;
        fall_r  <= 1'b0;
      end else if (accept_s) begin
        cnt_r   <= CNT_ZERO;
        busy_r  <= 1'b0;
        level_r <= sample_s;
        rise_r  <= sample_s;
        fall_r  <= ~sample_s;
      end else begin
        // cnt stays below Teff-1 here, so cnt+1 is non-zero and cannot wrap
        cnt_r   <= cnt_r + CNT_ONE;
        busy_r  <= 1'b1;
        rise_r  <= 1'b0;
        fall_r  <= 1'b0;
      end
    end

    // Sticky event flag; a coinciding set beats the clear
    always_ff @(posedge iCLK) begin
      if (iRST) begin
        event_r <= 1'b0;
      end else if (set_s) begin
        event_r <= 1'b1;
      end else if (iEvent_clr[i]) begin
        event_r <= 1'b0;
      end else begin
        event_r <= event_r;
      end
    end

    assign oLevel[i]        = level_r;
    assign oRising_edge[i]  = rise_r;
    assign oFalling_edge[i] = fall_r;
    assign oEvent[i]        = event_r;
    assign oBusy[i]         = busy_r;
  end

endmodule
